// File: rtl/b_format_decoder.sv
// B-form (bc/bca/bcl/bcla) decoder: recognises primary opcode 16 on the B-form
// lane and registers a branch-unit micro-op one cycle after issue.
module b_format_decoder #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 6,
  parameter int regSize                 = 5,
  parameter int immediateSize           = 14,
  parameter int funcUnitCodeSize        = 3,
  parameter int BranchUnitID            = 6,
  parameter int BOpcode                 = 16,
  parameter int BFormatBit              = 24,
  parameter int formatCount             = 26
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 enable_i,
  input  logic                                 stall_i,
  input  logic [0:formatCount-1]               instFormat_i,
  input  logic [opcodeSize-1:0]                instructionOpcode_i,
  input  logic [0:instructionWidth-1]          instruction_i,
  input  logic [addressWidth-1:0]              instructionAddress_i,
  input  logic                                 is64Bit_i,
  input  logic [PidSize-1:0]                   instructionPid_i,
  input  logic [TidSize-1:0]                   instructionTid_i,
  input  logic [instructionCounterWidth-1:0]   instructionMajId_i,
  output logic                                 enable_o,
  output logic [opcodeSize-1:0]                instructionOpcode_o,
  output logic [addressWidth-1:0]              instructionAddress_o,
  output logic [funcUnitCodeSize-1:0]          functionalUnitType_o,
  output logic [0:instructionCounterWidth]     instMajId_o,
  output logic [instMinIdWidth-1:0]            instMinId_o,
  output logic                                 is64Bit_o,
  output logic [PidSize-1:0]                   instPid_o,
  output logic [TidSize-1:0]                   instTid_o,
  output logic [0:2*regSize+immediateSize+3]   instructionBody_o
);

  localparam int bodyWidth = 2 * regSize + immediateSize + 4;
  localparam int boPos     = opcodeSize;
  localparam int biPos     = boPos + regSize;
  localparam int bdPos     = biPos + regSize;
  localparam int aaPos     = bdPos + immediateSize;
  localparam int lkPos     = aaPos + 1;

  // Body layout: BO | BI | BD (raw) | AA | LK | decrement-CTR | test-condition
  function automatic logic [0:bodyWidth-1] decodeBody(input logic [0:instructionWidth-1] inst);
    logic [0:regSize-1] bo;
    bo = inst[boPos +: regSize];
    return {bo, inst[biPos +: regSize], inst[bdPos +: immediateSize],
            inst[aaPos], inst[lkPos], ~bo[2], ~bo[0]};
  endfunction

  logic accept_p0;

  logic                               vld_p1;
  logic [opcodeSize-1:0]              opcode_p1;
  logic [addressWidth-1:0]            address_p1;
  logic [funcUnitCodeSize-1:0]        funcUnit_p1;
  logic [0:instructionCounterWidth]   majId_p1;
  logic [instMinIdWidth-1:0]          minId_p1;
  logic                               is64Bit_p1;
  logic [PidSize-1:0]                 pid_p1;
  logic [TidSize-1:0]                 tid_p1;
  logic [0:bodyWidth-1]               body_p1;

  assign accept_p0 = enable_i & instFormat_i[BFormatBit] &
                     (instructionOpcode_i == opcodeSize'(BOpcode)) & ~stall_i;

  // Stage p0 -> p1: a stall freezes the whole record, including the valid flag
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      vld_p1      <= 1'b0;
      opcode_p1   <= '0;
      address_p1  <= '0;
      funcUnit_p1 <= '0;
      majId_p1    <= '0;
      minId_p1    <= '0;
      is64Bit_p1  <= 1'b0;
      pid_p1      <= '0;
      tid_p1      <= '0;
      body_p1     <= '0;
    end else if (!stall_i) begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        opcode_p1   <= instructionOpcode_i;
        address_p1  <= instructionAddress_i;
        funcUnit_p1 <= funcUnitCodeSize'(BranchUnitID);
        majId_p1    <= {1'b0, instructionMajId_i};
        minId_p1    <= '0;
        is64Bit_p1  <= is64Bit_i;
        pid_p1      <= instructionPid_i;
        tid_p1      <= instructionTid_i;
        body_p1     <= decodeBody(instruction_i);
      end
    end
  end

  assign enable_o             = vld_p1;
  assign instructionOpcode_o  = opcode_p1;
  assign instructionAddress_o = address_p1;
  assign functionalUnitType_o = funcUnit_p1;
  assign instMajId_o          = majId_p1;
  assign instMinId_o          = minId_p1;
  assign is64Bit_o            = is64Bit_p1;
  assign instPid_o            = pid_p1;
  assign instTid_o            = tid_p1;
  assign instructionBody_o    = body_p1;

endmodule

// File: tb/tb_b_format_decoder.sv
// Scoreboard bench for b_format_decoder: a driver pushes the expected output
// record per clock, a monitor pops and compares one cycle later.
module tb_b_format_decoder;

  logic        clk, clkRun;
  logic        reset_i, enable_i, stall_i;
  logic [0:25] instFormat;
  logic [5:0]  opc;
  logic [0:31] instr;
  logic [63:0] addr, maj;
  logic        is64;
  logic [19:0] pid;
  logic [15:0] tid;

  logic        enO, is64O;
  logic [5:0]  opcO;
  logic [63:0] addrO;
  logic [2:0]  fuO;
  logic [0:64] majO;
  logic [6:0]  minO;
  logic [19:0] pidO;
  logic [15:0] tidO;
  logic [0:27] bodyO;

  b_format_decoder dut (
    .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i), .stall_i(stall_i),
    .instFormat_i(instFormat), .instructionOpcode_i(opc), .instruction_i(instr),
    .instructionAddress_i(addr), .is64Bit_i(is64), .instructionPid_i(pid),
    .instructionTid_i(tid), .instructionMajId_i(maj),
    .enable_o(enO), .instructionOpcode_o(opcO), .instructionAddress_o(addrO),
    .functionalUnitType_o(fuO), .instMajId_o(majO), .instMinId_o(minO),
    .is64Bit_o(is64O), .instPid_o(pidO), .instTid_o(tidO), .instructionBody_o(bodyO)
  );

  typedef struct packed {
    logic        en;
    logic [5:0]  opc;
    logic [63:0] addr;
    logic [2:0]  fu;
    logic [64:0] maj;
    logic [6:0]  min;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [27:0] body;
  } rec_t;

  rec_t expq[$];
  rec_t model;
  int   compared = 0;
  int   mismatched = 0;
  int   cycleNo = 0;
  logic [0:25] fmtB, fmtD;

  initial begin
    clk = 0;
    forever #5 clk = clkRun ? ~clk : clk;
  end

  function automatic rec_t actual();
    rec_t a;
    a.en = enO; a.opc = opcO; a.addr = addrO; a.fu = fuO; a.maj = majO;
    a.min = minO; a.is64 = is64O; a.pid = pidO; a.tid = tidO; a.body = bodyO;
    return a;
  endfunction

  task automatic checkRec(input string name, input rec_t e);
    rec_t a;
    a = actual();
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got en=%b opc=%h addr=%h fu=%h maj=%h min=%h is64=%b pid=%h tid=%h body=%b | expected en=%b opc=%h addr=%h fu=%h maj=%h min=%h is64=%b pid=%h tid=%h body=%b",
               name, a.en, a.opc, a.addr, a.fu, a.maj, a.min, a.is64, a.pid, a.tid, a.body,
               e.en, e.opc, e.addr, e.fu, e.maj, e.min, e.is64, e.pid, e.tid, e.body);
    end
  endtask

  task automatic checkVal(input string name, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference decode from the field rules, word held as a plain 32-bit number
  function automatic logic [27:0] bodyOf(input logic [31:0] w);
    logic [4:0]  bo, bi;
    logic [13:0] bd;
    bo = 5'((w >> 21) & 32'h1f);
    bi = 5'((w >> 16) & 32'h1f);
    bd = 14'((w >> 2) & 32'h3fff);
    return {bo, bi, bd, w[1], w[0], ~bo[2], ~bo[4]};
  endfunction

  function automatic logic [31:0] mkWord(input logic [5:0] op, input logic [4:0] bo,
                                         input logic [4:0] bi, input logic [13:0] bd,
                                         input logic aa, input logic lk);
    return {op, bo, bi, bd, aa, lk};
  endfunction

  task automatic drive(input bit en, input bit st, input logic [0:25] fmt, input logic [5:0] op,
                       input logic [31:0] w, input logic [63:0] a, input bit m64,
                       input logic [19:0] p, input logic [15:0] t, input logic [63:0] mj);
    @(negedge clk);
    enable_i = en; stall_i = st; instFormat = fmt; opc = op; instr = w;
    addr = a; is64 = m64; pid = p; tid = t; maj = mj;
    if (en && fmt[24] && op == 6'd16 && !st) begin
      model.en = 1'b1; model.opc = op; model.addr = a; model.fu = 3'd6;
      model.maj = {1'b0, mj}; model.min = '0; model.is64 = m64;
      model.pid = p; model.tid = t; model.body = bodyOf(w);
    end else if (!st) begin
      model.en = 1'b0;
    end
    expq.push_back(model);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycleNo++;
      if (expq.size() > 0) checkRec($sformatf("cycle%0d", cycleNo), expq.pop_front());
    end
  end

  initial begin
    logic [31:0] w;
    logic [5:0]  op;
    logic [0:25] f;
    clkRun = 0; reset_i = 1; enable_i = 0; stall_i = 0; instFormat = '0; opc = '0;
    instr = '0; addr = '0; is64 = 0; pid = '0; tid = '0; maj = '0;
    fmtB = '0; fmtB[24] = 1'b1;
    fmtD = '0; fmtD[3] = 1'b1;
    model = '0;

    #3 reset_i = 0;
    #2 checkRec("resetNoClock", '0);
    clkRun = 1;
    repeat (2) @(negedge clk);
    reset_i = 1;
    drive(0, 0, fmtB, 6'd16, '0, '0, 0, '0, '0, '0);
    drive(0, 0, fmtB, 6'd16, '0, '0, 0, '0, '0, '0);

    for (int i = 0; i <= 62; i++) begin
      op = 6'(i);
      w = mkWord(op, 5'b01110, 5'b10001, 14'b00001111111100, ~op[0], op[0]);
      drive(1, 0, fmtB, op, w, 64'(i), 1, 20'h12345, 16'h6789, 64'(i));
    end

    w = mkWord(6'd16, 5'b01110, 5'b10001, 14'b00001111111100, 1'b1, 1'b0);
    drive(1, 0, fmtB, 6'd16, w, 64'd16, 1, 20'habcde, 16'h1234, 64'd16);
    @(posedge clk); #2;
    checkVal("exampleBody", bodyO, 128'b0111010001000011111111001001);
    checkVal("exampleFu", fuO, 128'b110);
    checkVal("exampleMaj", majO, 128'd16);
    checkVal("exampleMin", minO, 128'd0);
    checkVal("exampleAddr", addrO, 128'd16);

    drive(1, 0, fmtD, 6'd16, mkWord(6'd16, 5'b00100, 5'd3, 14'h155, 0, 1), 64'hdead, 0, 20'h1, 16'h2, 64'h99);
    drive(1, 0, fmtB, 6'd16, mkWord(6'd16, 5'b00001, 5'd7, 14'h2aa, 0, 0), 64'h1000, 1, 20'h3, 16'h4, 64'h100);
    drive(1, 1, fmtB, 6'd16, mkWord(6'd16, 5'b11111, 5'd9, 14'h3ff, 1, 1), 64'h2000, 0, 20'h5, 16'h6, 64'h200);
    drive(1, 1, fmtB, 6'd16, mkWord(6'd16, 5'b10000, 5'd1, 14'h001, 1, 0), 64'h3000, 0, 20'h7, 16'h8, 64'h300);
    drive(1, 0, fmtB, 6'd16, mkWord(6'd16, 5'b01010, 5'd2, 14'h0f0, 0, 1), 64'h4000, 1, 20'h9, 16'ha, 64'h400);
    drive(0, 0, fmtB, 6'd16, '0, '0, 0, '0, '0, '0);
    drive(0, 1, fmtB, 6'd16, '0, '0, 0, '0, '0, '0);

    drive(1, 0, fmtB, 6'd16, mkWord(6'd16, 5'b10100, 5'd0, 14'd0, 0, 0), 64'h10, 0, '0, '0, 64'h1);
    @(posedge clk); #2;
    checkVal("bo10100ctr", bodyO[26], 128'd0);
    checkVal("bo10100cond", bodyO[27], 128'd0);
    drive(1, 0, fmtB, 6'd16, mkWord(6'd16, 5'b00000, 5'd0, 14'd0, 0, 0), 64'h20, 0, '0, '0, 64'h2);
    @(posedge clk); #2;
    checkVal("bo00000ctr", bodyO[26], 128'd1);
    checkVal("bo00000cond", bodyO[27], 128'd1);

    drive(1, 0, fmtB, 6'd16, mkWord(6'd16, 5'b01100, 5'd4, 14'h123, 1, 1), 64'h30, 1, 20'hf, 16'hf, 64'h3);
    @(negedge clk);
    enable_i = 1; stall_i = 0; instFormat = fmtB; opc = 6'd16;
    instr = mkWord(6'd16, 5'b00110, 5'd5, 14'h321, 0, 1);
    #1 reset_i = 0;
    #1 checkRec("resetMidStream", '0);
    model = '0;
    @(negedge clk);
    enable_i = 0;
    reset_i = 1;
    #1 checkVal("releaseNoEdge", enO, 128'd0);
    drive(0, 0, fmtB, 6'd16, '0, '0, 0, '0, '0, '0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) f = fmtB;
      else begin f = '0; f[$urandom_range(0, 25)] = 1'b1; end
      op = ($urandom_range(0, 9) < 6) ? 6'd16 : 6'($urandom_range(0, 63));
      w = {op, 26'($urandom)};
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, f, op, w,
            {$urandom, $urandom}, 1'($urandom), 20'($urandom), 16'($urandom),
            {$urandom, $urandom});
    end

    @(posedge clk); #3;
    checkVal("queueDrained", 128'(expq.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
